// File: rtl/multicycle_pkg.sv
// Shared types and select codes for the multicycle MIPS control unit.
// State encodings are visible on the debug state port, so keep them fixed.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_BNE  = 3'd4
  } cls_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_OFFSET = 2'b11;

  // States whose exit back to FETCH completes an instruction.
  function automatic logic retires(state_t s);
    case (s)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retires = 1'b1;
      default:                                                  retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Opcode lookup used in DECODE: gives the state to enter and the class to latch.
// Unknown opcodes (and bne when disabled) route to TRAP.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int OP_RTYPE = 0,
  parameter int OP_LW    = 35,
  parameter int OP_SW    = 43,
  parameter int OP_BEQ   = 4,
  parameter int OP_BNE   = 5,
  parameter int OP_ADDI  = 8,
  parameter int OP_J     = 2,
  parameter bit EN_BNE   = 1'b1
) (
  input  logic [OP_W-1:0] op,
  output logic [3:0]      next_state,
  output logic [2:0]      next_class
);

  always_comb begin
    next_state = S_TRAP;
    next_class = CLS_NONE;
    if (op == OP_W'(OP_LW)) begin
      next_state = S_MEMADR;
      next_class = CLS_LW;
    end else if (op == OP_W'(OP_SW)) begin
      next_state = S_MEMADR;
      next_class = CLS_SW;
    end else if (op == OP_W'(OP_RTYPE)) begin
      next_state = S_EXECUTE;
    end else if (op == OP_W'(OP_BEQ)) begin
      next_state = S_BRANCH;
      next_class = CLS_BEQ;
    end else if (EN_BNE && (op == OP_W'(OP_BNE))) begin
      next_state = S_BRANCH;
      next_class = CLS_BNE;
    end else if (op == OP_W'(OP_ADDI)) begin
      next_state = S_ADDIEX;
    end else if (op == OP_W'(OP_J)) begin
      next_state = S_JUMP;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with memory-ready stalls,
// a latched instruction class, a sticky illegal-opcode trap and a retire counter.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int OP_RTYPE = 0,
  parameter int OP_LW    = 35,
  parameter int OP_SW    = 43,
  parameter int OP_BEQ   = 4,
  parameter int OP_BNE   = 5,
  parameter int OP_ADDI  = 8,
  parameter int OP_J     = 2,
  parameter bit EN_BNE   = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  OP,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic             MemWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             mem_req,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t     cur;
  state_t     nxt;
  cls_t       cls;
  logic [3:0] dec_state;
  logic [2:0] dec_class;

  multicycle_ctrl_decode #(
    .OP_W     (OP_W),
    .OP_RTYPE (OP_RTYPE),
    .OP_LW    (OP_LW),
    .OP_SW    (OP_SW),
    .OP_BEQ   (OP_BEQ),
    .OP_BNE   (OP_BNE),
    .OP_ADDI  (OP_ADDI),
    .OP_J     (OP_J),
    .EN_BNE   (EN_BNE)
  ) u_decode (
    .op         (OP),
    .next_state (dec_state),
    .next_class (dec_class)
  );

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = state_t'(dec_state);
      // Routing after DECODE relies on the latched class; OP may have moved on.
      S_MEMADR:   nxt = (cls == CLS_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEX:   nxt = S_ADDIWB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur     <= S_FETCH;
      cls     <= CLS_NONE;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) cls <= cls_t'(dec_class);
      if (retires(cur) && (nxt == S_FETCH)) retired <= retired + CNT_W'(1);
    end
  end

  assign state = cur;

  // Moore decode; only the FETCH strobes look at mem_ready.
  always_comb begin
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    MemWrite = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    mem_req  = 1'b0;
    trap     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_OFFSET;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        mem_req  = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSrc    = PCSRC_ALUOUT;
        Branch   = (cls == CLS_BEQ);
        BranchNe = (cls == CLS_BNE);
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instance a uses defaults, instance b has
// bne disabled and a 4-bit retire counter.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed controls: {IorD,ALUSrcA}_{IRWrite,PCWrite}_{RegDst,MemtoReg,RegWrite}_
  // {Branch,BranchNe,MemWrite}_ALUSrcB_ALUOp_PCSrc_{mem_req,trap}
  localparam logic [17:0] C_F1    = 18'b00_11_000_000_01_00_00_10;
  localparam logic [17:0] C_F0    = 18'b00_00_000_000_01_00_00_10;
  localparam logic [17:0] C_DEC   = 18'b00_00_000_000_11_00_00_00;
  localparam logic [17:0] C_MADR  = 18'b01_00_000_000_10_00_00_00;
  localparam logic [17:0] C_MREAD = 18'b10_00_000_000_00_00_00_10;
  localparam logic [17:0] C_MWB   = 18'b00_00_011_000_00_00_00_00;
  localparam logic [17:0] C_MWR   = 18'b10_00_000_001_00_00_00_10;
  localparam logic [17:0] C_EXEC  = 18'b01_00_000_000_00_10_00_00;
  localparam logic [17:0] C_ALUWB = 18'b00_00_101_000_00_00_00_00;
  localparam logic [17:0] C_BEQ   = 18'b01_00_000_100_00_01_01_00;
  localparam logic [17:0] C_BNE   = 18'b01_00_000_010_00_01_01_00;
  localparam logic [17:0] C_AIWB  = 18'b00_00_001_000_00_00_00_00;
  localparam logic [17:0] C_JUMP  = 18'b00_01_000_000_00_00_10_00;
  localparam logic [17:0] C_TRAP  = 18'b00_00_000_000_00_00_00_01;

  logic        rst_a, rdy_a;
  logic [5:0]  op_a;
  logic        a_iord, a_srca, a_irw, a_pcw, a_rdst, a_m2r, a_regw, a_br, a_brne, a_memw;
  logic [1:0]  a_srcb, a_aluop, a_pcsrc;
  logic        a_req, a_trap;
  logic [3:0]  st_a;
  logic [31:0] ret_a;
  logic [17:0] ctl_a;

  logic        rst_b, rdy_b;
  logic [5:0]  op_b;
  logic        b_iord, b_srca, b_irw, b_pcw, b_rdst, b_m2r, b_regw, b_br, b_brne, b_memw;
  logic [1:0]  b_srcb, b_aluop, b_pcsrc;
  logic        b_req, b_trap;
  logic [3:0]  st_b;
  logic [3:0]  ret_b;
  logic [17:0] ctl_b;

  assign ctl_a = {a_iord, a_srca, a_irw, a_pcw, a_rdst, a_m2r, a_regw, a_br, a_brne, a_memw,
                  a_srcb, a_aluop, a_pcsrc, a_req, a_trap};
  assign ctl_b = {b_iord, b_srca, b_irw, b_pcw, b_rdst, b_m2r, b_regw, b_br, b_brne, b_memw,
                  b_srcb, b_aluop, b_pcsrc, b_req, b_trap};

  multicycle_ctrl u_dut_a (
    .clk(clk), .rst(rst_a), .OP(op_a), .mem_ready(rdy_a),
    .IorD(a_iord), .ALUSrcA(a_srca), .IRWrite(a_irw), .PCWrite(a_pcw), .RegDst(a_rdst),
    .MemtoReg(a_m2r), .RegWrite(a_regw), .Branch(a_br), .BranchNe(a_brne), .MemWrite(a_memw),
    .ALUSrcB(a_srcb), .ALUOp(a_aluop), .PCSrc(a_pcsrc), .mem_req(a_req), .trap(a_trap),
    .state(st_a), .retired(ret_a)
  );

  multicycle_ctrl #(.EN_BNE(1'b0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .OP(op_b), .mem_ready(rdy_b),
    .IorD(b_iord), .ALUSrcA(b_srca), .IRWrite(b_irw), .PCWrite(b_pcw), .RegDst(b_rdst),
    .MemtoReg(b_m2r), .RegWrite(b_regw), .Branch(b_br), .BranchNe(b_brne), .MemWrite(b_memw),
    .ALUSrcB(b_srcb), .ALUOp(b_aluop), .PCSrc(b_pcsrc), .mem_req(b_req), .trap(b_trap),
    .state(st_b), .retired(ret_b)
  );

  task automatic do_reset_a();
    @(negedge clk); rst_a = 1'b0; rdy_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
  endtask

  task automatic do_reset_b();
    @(negedge clk); rst_b = 1'b0; rdy_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL reset_state_a got %0d want 0", st_a); end
    n_checks++; if (ctl_a !== C_F0) begin n_fail++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, C_F0); end
    n_checks++; if (ret_a !== 32'd0) begin n_fail++; $display("FAIL reset_retired_a got %0d want 0", ret_a); end
    n_checks++; if (st_b !== 4'd0) begin n_fail++; $display("FAIL reset_state_b got %0d want 0", st_b); end
    n_checks++; if (ret_b !== 4'd0) begin n_fail++; $display("FAIL reset_retired_b got %0d want 0", ret_b); end
    rdy_a = 1'b1; #1;
    n_checks++; if (ctl_a !== C_F1) begin n_fail++; $display("FAIL reset_strobes got %b want %b", ctl_a, C_F1); end
    rdy_a = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_lw();
    int          ops [6] = '{35, 35, 43, 43, 0, 0};
    int          rdy [6] = '{1, 1, 1, 1, 1, 0};
    int          est [6] = '{0, 1, 2, 3, 4, 0};
    logic [17:0] ect [6] = '{C_F1, C_DEC, C_MADR, C_MREAD, C_MWB, C_F0};
    do_reset_a();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); op_a = 6'(ops[i]); rdy_a = (rdy[i] != 0); #1;
      n_checks++; if (st_a !== 4'(est[i])) begin n_fail++; $display("FAIL lw_state cyc%0d got %0d want %0d", i, st_a, est[i]); end
      n_checks++; if (ctl_a !== ect[i]) begin n_fail++; $display("FAIL lw_ctl cyc%0d got %b want %b", i, ctl_a, ect[i]); end
    end
    n_checks++; if (ret_a !== 32'd1) begin n_fail++; $display("FAIL lw_retired got %0d want 1", ret_a); end
  endtask

  task automatic test_sw_stall();
    int          ops [8] = '{43, 43, 35, 35, 35, 35, 35, 0};
    int          rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    int          est [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
    logic [17:0] ect [8] = '{C_F1, C_DEC, C_MADR, C_MWR, C_MWR, C_MWR, C_MWR, C_F0};
    do_reset_a();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); op_a = 6'(ops[i]); rdy_a = (rdy[i] != 0); #1;
      n_checks++; if (st_a !== 4'(est[i])) begin n_fail++; $display("FAIL sw_state cyc%0d got %0d want %0d", i, st_a, est[i]); end
      n_checks++; if (ctl_a !== ect[i]) begin n_fail++; $display("FAIL sw_ctl cyc%0d got %b want %b", i, ctl_a, ect[i]); end
      if (i == 5) begin
        n_checks++; if (ret_a !== 32'd0) begin n_fail++; $display("FAIL sw_stall_retired got %0d want 0", ret_a); end
      end
    end
    n_checks++; if (ret_a !== 32'd1) begin n_fail++; $display("FAIL sw_retired got %0d want 1", ret_a); end
  endtask

  task automatic test_branch();
    int          ops [8] = '{4, 4, 4, 0, 5, 5, 5, 0};
    int          rdy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int          est [8] = '{0, 0, 1, 8, 0, 1, 8, 0};
    logic [17:0] ect [8] = '{C_F0, C_F1, C_DEC, C_BEQ, C_F1, C_DEC, C_BNE, C_F0};
    do_reset_a();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); op_a = 6'(ops[i]); rdy_a = (rdy[i] != 0); #1;
      n_checks++; if (st_a !== 4'(est[i])) begin n_fail++; $display("FAIL br_state cyc%0d got %0d want %0d", i, st_a, est[i]); end
      n_checks++; if (ctl_a !== ect[i]) begin n_fail++; $display("FAIL br_ctl cyc%0d got %b want %b", i, ctl_a, ect[i]); end
    end
    n_checks++; if (ret_a !== 32'd2) begin n_fail++; $display("FAIL br_retired got %0d want 2", ret_a); end
  endtask

  task automatic test_back_to_back();
    int          ops [12] = '{0, 0, 0, 0, 8, 8, 8, 8, 2, 2, 2, 0};
    int          est [12] = '{0, 1, 6, 7, 0, 1, 9, 10, 0, 1, 11, 0};
    logic [17:0] ect [12] = '{C_F1, C_DEC, C_EXEC, C_ALUWB, C_F1, C_DEC, C_MADR, C_AIWB,
                              C_F1, C_DEC, C_JUMP, C_F0};
    do_reset_a();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); op_a = 6'(ops[i]); rdy_a = (i != 11); #1;
      n_checks++; if (st_a !== 4'(est[i])) begin n_fail++; $display("FAIL b2b_state cyc%0d got %0d want %0d", i, st_a, est[i]); end
      n_checks++; if (ctl_a !== ect[i]) begin n_fail++; $display("FAIL b2b_ctl cyc%0d got %b want %b", i, ctl_a, ect[i]); end
    end
    n_checks++; if (ret_a !== 32'd3) begin n_fail++; $display("FAIL b2b_retired got %0d want 3", ret_a); end
  endtask

  task automatic test_trap();
    @(negedge clk); op_a = 6'd63; rdy_a = 1'b1; #1;
    n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL trap_pre_state got %0d want 0", st_a); end
    @(negedge clk); #1;
    n_checks++; if (st_a !== 4'd1) begin n_fail++; $display("FAIL trap_dec_state got %0d want 1", st_a); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); op_a = 6'(i); #1;
      n_checks++; if (st_a !== 4'd12) begin n_fail++; $display("FAIL trap_state cyc%0d got %0d want 12", i, st_a); end
      n_checks++; if (ctl_a !== C_TRAP) begin n_fail++; $display("FAIL trap_ctl cyc%0d got %b want %b", i, ctl_a, C_TRAP); end
    end
    n_checks++; if (ret_a !== 32'd3) begin n_fail++; $display("FAIL trap_retired got %0d want 3", ret_a); end
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1; rdy_a = 1'b0; #1;
    n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL trap_rst_state got %0d want 0", st_a); end
    n_checks++; if (ctl_a !== C_F0) begin n_fail++; $display("FAIL trap_rst_ctl got %b want %b", ctl_a, C_F0); end
    n_checks++; if (ret_a !== 32'd0) begin n_fail++; $display("FAIL trap_rst_retired got %0d want 0", ret_a); end
  endtask

  task automatic test_bne_disabled();
    int est [4] = '{0, 1, 12, 12};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); op_b = 6'd5; rdy_b = 1'b1; #1;
      n_checks++; if (st_b !== 4'(est[i])) begin n_fail++; $display("FAIL bnedis_state cyc%0d got %0d want %0d", i, st_b, est[i]); end
    end
    n_checks++; if (ctl_b !== C_TRAP) begin n_fail++; $display("FAIL bnedis_ctl got %b want %b", ctl_b, C_TRAP); end
    do_reset_b();
  endtask

  task automatic test_reset_stall();
    int          rdy [6] = '{1, 1, 1, 0, 0, 0};
    int          rsv [6] = '{1, 1, 1, 1, 0, 1};
    int          est [6] = '{0, 1, 2, 3, 3, 0};
    logic [17:0] ect [6] = '{C_F1, C_DEC, C_MADR, C_MREAD, C_MREAD, C_F0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); op_b = 6'd35; rdy_b = (rdy[i] != 0); rst_b = (rsv[i] != 0); #1;
      n_checks++; if (st_b !== 4'(est[i])) begin n_fail++; $display("FAIL rststall_state cyc%0d got %0d want %0d", i, st_b, est[i]); end
      n_checks++; if (ctl_b !== ect[i]) begin n_fail++; $display("FAIL rststall_ctl cyc%0d got %b want %b", i, ctl_b, ect[i]); end
    end
    n_checks++; if (ret_b !== 4'd0) begin n_fail++; $display("FAIL rststall_retired got %0d want 0", ret_b); end
  endtask

  task automatic test_wrap();
    int est [4] = '{0, 1, 6, 7};
    for (int k = 0; k < 17; k++) begin
      for (int p = 0; p < 4; p++) begin
        @(negedge clk); op_b = 6'd0; rdy_b = 1'b1; #1;
        n_checks++; if (st_b !== 4'(est[p])) begin n_fail++; $display("FAIL wrap_state ins%0d ph%0d got %0d want %0d", k, p, st_b, est[p]); end
        if (k == 16 && p == 0) begin
          n_checks++; if (ret_b !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got %0d want 0", ret_b); end
        end
      end
    end
    @(negedge clk); rdy_b = 1'b0; #1;
    n_checks++; if (st_b !== 4'd0) begin n_fail++; $display("FAIL wrap_end_state got %0d want 0", st_b); end
    n_checks++; if (ret_b !== 4'd1) begin n_fail++; $display("FAIL wrap_retired got %0d want 1", ret_b); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; op_a = '0; op_b = '0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_back_to_back();
    test_trap();
    test_bne_disabled();
    test_reset_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle MIPS control unit: the next generation of the team's Moore control FSM. It sequences fetch/decode/execute/writeback for lw, sw, R-type, beq, bne, addi and j, and adds three things: a memory-ready handshake that stalls memory states, a latched instruction class, and a sticky trap on illegal opcodes. It also keeps a retired-instruction counter. It sits between the instruction register (source of OP) and the multicycle datapath and memory.

## Interface
- OP_W, 6, opcode width
- OP_RTYPE / OP_LW / OP_SW / OP_BEQ / OP_BNE / OP_ADDI / OP_J, 0/35/43/4/5/8/2, opcode values
- EN_BNE, 1, 0: OP_BNE decodes as illegal
- CNT_W, 32, retired-instruction counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-low reset
- OP  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory completes current access this cycle
- IorD, ALUSrcA, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite, Branch, BranchNe, MemWrite  out  1  datapath controls
- ALUSrcB, ALUOp, PCSrc  out  2  datapath selects
- mem_req  out  1  memory access requested
- trap  out  1  illegal opcode seen, sticky
- state  out  4  current state encoding (debug)
- retired  out  CNT_W  instructions completed

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12; 13–15 go to FETCH next cycle, all outputs 0.
- Transitions:
  - FETCH→DECODE when mem_ready, else hold.
  - DECODE routes by OP: lw/sw→MEMADR, R-type→EXECUTE, beq/bne→BRANCH, addi→ADDIEX, j→JUMP, other→TRAP.
  - MEMADR→MEMREAD if class lw, MEMWRITE if sw.
  - MEMREAD→MEMWB when mem_ready, else hold.
  - MEMWRITE→FETCH when mem_ready, else hold.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
  - TRAP holds until reset.
- Instruction class (lw/sw/beq/bne) is registered in DECODE. Later routing uses the latched class, never live OP.
- Outputs are a function of state only, except the FETCH strobes. Every output not listed for a state is 0.
  - FETCH: mem_req=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD: IorD=1, mem_req=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1, mem_req=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1 for beq or BranchNe=1 for bne.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
  - TRAP: trap=1.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH or JUMP. It wraps modulo 2^CNT_W.

## Timing
- rst low at a clk edge: state=FETCH, class cleared, retired=0, trap=0.
- Outputs during and after reset equal FETCH values: mem_req=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready, all else 0.
- Reset mid-instruction or in TRAP aborts to FETCH the next edge. No pending write is completed.
- Latency with mem_ready held high:
  - lw: 5 cycles; sw: 4; R-type: 4; addi: 4; beq/bne: 3; j: 3.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_req and addressing controls stay stable throughout a stall. A write strobe (MemWrite) is held high until the mem_ready cycle.
- OP is sampled only in DECODE and may change afterwards.

## Structure
- Package multicycle_pkg holds:
  - the state enum and its encoding;
  - the ALUOp codes (ADD 00, SUB 01, FUNCT 10);
  - the PCSrc codes (ALU 00, ALUOUT 01, JUMP 10);
  - the ALUSrcB codes.
- One sub-module, multicycle_ctrl_decode: combinational OP→next-class/next-state lookup, parametrised by the opcode values and EN_BNE.
- The state register, class register, output decode and counter live in the top module.

## Test plan
- lw, mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5. retired 0→1.
- sw, mem_ready low for 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, then FETCH. Total 7 cycles. RegWrite never 1.
- beq then bne (EN_BNE=1): Branch=1/BranchNe=0, then BranchNe=1/Branch=0. Each takes 3 cycles. retired=2.
- OP=63 in DECODE: TRAP next cycle, trap=1 held for 20 cycles. rst low for 1 cycle: FETCH with trap=0, retired=0.
- EN_BNE=0 with OP=5: TRAP. Reset asserted during MEMREAD stall: next state FETCH, RegWrite stays 0.
- CNT_W=4 with 17 R-type instructions: retired wraps to 1.
